// File: rtl/output_divide_round_if.sv
// output_divide_round_if: operand stream into the divider and the pixel stream out of it.
// master drives DataIn/Denom/StartIn and observes StartOut/PixelOut/PixelCount/FrameDone.
// slave is the opposite side.
interface output_divide_round_if #(parameter int CNT_W = 19);
  logic [27:0] DataIn;
  logic [19:0] Denom;
  logic StartIn;
  logic StartOut;
  logic [7:0] PixelOut;
  logic [CNT_W-1:0] PixelCount;
  logic FrameDone;
  modport master (output DataIn, Denom, StartIn, input StartOut, PixelOut, PixelCount, FrameDone);
  modport slave (input DataIn, Denom, StartIn, output StartOut, PixelOut, PixelCount, FrameDone);
endinterface

// File: rtl/output_divide_round.sv
// output_divide_round: 10-stage pipelined round-to-nearest divide producing saturated 8-bit pixels.
// clock/reset_n: rising-edge clock, async active-low reset.
// bus.DataIn/Denom/StartIn: numerator, denominator, operand valid.
// bus.StartOut/PixelOut: result valid and pixel. bus.PixelCount/FrameDone: per-frame counter and last-pixel pulse.
module output_divide_round #(
  parameter int NUM_PIXELS = 307200,
  parameter int CNT_W = 19
) (
  input logic clock,
  input logic reset_n,
  output_divide_round_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PIXELS - 1);
  logic [9:0] v_q;
  logic [27:0] r_q [9];
  logic [27:0] r_d [9];
  logic [19:0] d_q [9];
  logic [19:0] d_d [9];
  logic [7:0] q_q [9];
  logic [7:0] q_d [9];
  logic [8:0] z_q, z_d, ov_q, ov_d;
  logic [7:0] pix_q, pix_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [27:0] sh;
  logic ge, up;
  logic [8:0] qr;
  always_comb begin
    sh = '0;
    ge = 1'b0;
    r_d[0] = bus.StartIn ? bus.DataIn : '0;
    d_d[0] = bus.StartIn ? bus.Denom : '0;
    q_d[0] = '0;
    z_d[0] = bus.StartIn && bus.Denom == '0;
    ov_d[0] = bus.StartIn && bus.DataIn >= {bus.Denom, 8'd0};
    for (int k = 1; k < 9; k++) begin
      sh = {8'd0, d_q[k-1]} << (8 - k);
      ge = r_q[k-1] >= sh;
      r_d[k] = !v_q[k-1] ? '0 : ge ? r_q[k-1] - sh : r_q[k-1];
      d_d[k] = v_q[k-1] ? d_q[k-1] : '0;
      q_d[k] = v_q[k-1] ? q_q[k-1] | (8'(ge) << (8 - k)) : '0;
      z_d[k] = v_q[k-1] & z_q[k-1];
      ov_d[k] = v_q[k-1] & ov_q[k-1];
    end
    // remainder is below D here, so doubling it in 29 bits is exact
    up = {r_q[8], 1'b0} >= {9'd0, d_q[8]};
    qr = {1'b0, q_q[8]} + {8'd0, up};
    pix_d = (!v_q[8] || z_q[8]) ? '0 : (ov_q[8] || qr[8]) ? 8'd255 : qr[7:0];
    cnt_d = !v_q[9] ? cnt_q : cnt_q == LAST ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v_q <= '0;
      z_q <= '0;
      ov_q <= '0;
      pix_q <= '0;
      cnt_q <= '0;
      for (int k = 0; k < 9; k++) begin
        r_q[k] <= '0;
        d_q[k] <= '0;
        q_q[k] <= '0;
      end
    end else begin
      v_q <= {v_q[8:0], bus.StartIn};
      z_q <= z_d;
      ov_q <= ov_d;
      pix_q <= pix_d;
      cnt_q <= cnt_d;
      for (int k = 0; k < 9; k++) begin
        r_q[k] <= r_d[k];
        d_q[k] <= d_d[k];
        q_q[k] <= q_d[k];
      end
    end
  end
  assign bus.StartOut = v_q[9];
  assign bus.PixelOut = pix_q;
  assign bus.PixelCount = cnt_q;
  assign bus.FrameDone = v_q[9] && cnt_q == LAST;
endmodule

// File: tb/tb_output_divide_round.sv
// tb_output_divide_round: randomized and directed checks of the divider against an arithmetic model.
module tb_output_divide_round;
  typedef struct packed {
    logic [7:0] pix;
    logic [18:0] cnt;
    logic done;
    logic [31:0] cyc;
  } rec_t;
  logic clk = 0;
  logic reset_n = 0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int ecnt = 0;
  rec_t obs[$];
  rec_t exp_q[$];
  output_divide_round_if #(.CNT_W(19)) bus();
  output_divide_round #(.NUM_PIXELS(4), .CNT_W(19)) dut (.clock(clk), .reset_n(reset_n), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.StartOut === 1'b1) obs.push_back('{bus.PixelOut, bus.PixelCount, bus.FrameDone, 32'(cyc)});
  function automatic int model(longint n, longint d);
    longint q;
    if (d == 0) return 0;
    q = (2 * n + d) / (2 * d);
    return q > 255 ? 255 : int'(q);
  endfunction
  task automatic send(logic [27:0] n, logic [19:0] d, int want = -1);
    @(negedge clk);
    bus.DataIn = n;
    bus.Denom = d;
    bus.StartIn = 1;
    exp_q.push_back('{8'(want < 0 ? model(n, d) : want), 19'(ecnt), ecnt == 3, 32'(cyc + 10)});
    ecnt = (ecnt + 1) % 4;
  endtask
  task automatic idle(int k);
    repeat (k) begin
      @(negedge clk);
      bus.StartIn = 0;
      bus.DataIn = 28'($urandom);
      bus.Denom = 20'($urandom);
    end
  endtask
  task automatic wait_out(int n);
    idle(1);
    for (int i = 0; i < 40 && obs.size() < n; i++) idle(1);
    idle(2);
  endtask
  task automatic rand_op();
    logic [19:0] d;
    longint n;
    d = ($urandom % 2) ? 20'($urandom_range(1, 20)) : 20'($urandom);
    n = (d == 0) ? longint'($urandom % 1000) : longint'(d) * $urandom_range(0, 256) + $urandom % d;
    if ($urandom % 4 == 0) n = $urandom;
    send(28'(n), d);
  endtask
  task automatic test_reset();
    rec_t o, e;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++;
      if ({bus.StartOut, bus.PixelOut, bus.PixelCount, bus.FrameDone} !== '0) begin
        bad++;
        $display("FAIL reset_hold: got so=%0d pix=%0d cnt=%0d fd=%0d want all 0", bus.StartOut, bus.PixelOut, bus.PixelCount, bus.FrameDone);
      end
      bus.StartIn = i[0];
      bus.DataIn = 28'($urandom);
      bus.Denom = 20'($urandom_range(1, 16));
    end
    @(negedge clk);
    bus.StartIn = 0;
    reset_n = 1;
    idle(3);
    send(127500, 1000, 128);
    wait_out(1);
    total++;
    if (obs.size() != exp_q.size()) begin
      bad++;
      $display("FAIL reset_count: got %0d outputs want %0d", obs.size(), exp_q.size());
    end
    while (obs.size() && exp_q.size()) begin
      o = obs.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset_first: got pix=%0d cnt=%0d done=%0d cyc=%0d want pix=%0d cnt=%0d done=%0d cyc=%0d", o.pix, o.cnt, o.done, o.cyc, e.pix, e.cnt, e.done, e.cyc);
      end
    end
    obs.delete();
    exp_q.delete();
  endtask
  task automatic test_known();
    rec_t o, e;
    send(127500, 1000, 128);
    send(127000, 1000, 127);
    send(0, 1000, 0);
    send(255000, 1000, 255);
    wait_out(4);
    total++;
    if (obs.size() != exp_q.size()) begin
      bad++;
      $display("FAIL known_count: got %0d outputs want %0d", obs.size(), exp_q.size());
    end
    while (obs.size() && exp_q.size()) begin
      o = obs.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL known: got pix=%0d cnt=%0d done=%0d cyc=%0d want pix=%0d cnt=%0d done=%0d cyc=%0d", o.pix, o.cnt, o.done, o.cyc, e.pix, e.cnt, e.done, e.cyc);
      end
    end
    obs.delete();
    exp_q.delete();
  endtask
  task automatic test_edges();
    rec_t o, e;
    send(12345, 0, 0);
    send(300, 1, 255);
    send(764, 3, 255);
    send(28'hFFFFFFF, 20'hFFFFF, 255);
    send(255, 1, 255);
    send(254500, 1000, 255);
    send(254499, 1000, 254);
    send(28'(256 * 20'hFFFFF - 1), 20'hFFFFF, 255);
    send(0, 0, 0);
    send(0, 1, 0);
    wait_out(10);
    total++;
    if (obs.size() != exp_q.size()) begin
      bad++;
      $display("FAIL edges_count: got %0d outputs want %0d", obs.size(), exp_q.size());
    end
    while (obs.size() && exp_q.size()) begin
      o = obs.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL edges: got pix=%0d cnt=%0d done=%0d cyc=%0d want pix=%0d cnt=%0d done=%0d cyc=%0d", o.pix, o.cnt, o.done, o.cyc, e.pix, e.cnt, e.done, e.cyc);
      end
    end
    obs.delete();
    exp_q.delete();
  endtask
  task automatic test_back_to_back();
    rec_t o, e;
    for (int i = 0; i < 8; i++) send(i % 2 ? 510 : 2550, i % 2 ? 4 : 10, i % 2 ? 128 : 255);
    wait_out(8);
    total++;
    if (obs.size() != exp_q.size()) begin
      bad++;
      $display("FAIL b2b_count: got %0d outputs want %0d", obs.size(), exp_q.size());
    end
    while (obs.size() && exp_q.size()) begin
      o = obs.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL b2b: got pix=%0d cnt=%0d done=%0d cyc=%0d want pix=%0d cnt=%0d done=%0d cyc=%0d", o.pix, o.cnt, o.done, o.cyc, e.pix, e.cnt, e.done, e.cyc);
      end
    end
    obs.delete();
    exp_q.delete();
  endtask
  task automatic test_random();
    rec_t o, e;
    for (int i = 0; i < 150; i++) begin
      rand_op();
      if ($urandom % 3 == 0) idle($urandom_range(1, 2));
    end
    wait_out(150);
    total++;
    if (obs.size() != exp_q.size()) begin
      bad++;
      $display("FAIL random_count: got %0d outputs want %0d", obs.size(), exp_q.size());
    end
    while (obs.size() && exp_q.size()) begin
      o = obs.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL random: got pix=%0d cnt=%0d done=%0d cyc=%0d want pix=%0d cnt=%0d done=%0d cyc=%0d", o.pix, o.cnt, o.done, o.cyc, e.pix, e.cnt, e.done, e.cyc);
      end
    end
    obs.delete();
    exp_q.delete();
  endtask
  task automatic test_midreset();
    for (int i = 0; i < 12; i++) rand_op();
    @(posedge clk);
    #2;
    total++;
    if (bus.StartOut !== 1'b1) begin
      bad++;
      $display("FAIL midreset_pre: got StartOut=%0d want 1", bus.StartOut);
    end
    reset_n = 0;
    bus.StartIn = 0;
    #1;
    total++;
    if ({bus.StartOut, bus.PixelOut, bus.PixelCount, bus.FrameDone} !== '0) begin
      bad++;
      $display("FAIL midreset_clear: got so=%0d pix=%0d cnt=%0d fd=%0d want all 0", bus.StartOut, bus.PixelOut, bus.PixelCount, bus.FrameDone);
    end
    obs.delete();
    exp_q.delete();
    ecnt = 0;
    @(negedge clk);
    reset_n = 1;
    idle(20);
    total++;
    if (obs.size() != 0) begin
      bad++;
      $display("FAIL midreset_stale: got %0d outputs want 0", obs.size());
    end
    total++;
    if (bus.PixelCount !== '0) begin
      bad++;
      $display("FAIL midreset_count: got %0d want 0", bus.PixelCount);
    end
    obs.delete();
  endtask
  task automatic test_frame();
    rec_t o, e;
    for (int i = 0; i < 9; i++) begin
      rand_op();
      idle($urandom_range(0, 2));
    end
    wait_out(9);
    total++;
    if (obs.size() != exp_q.size()) begin
      bad++;
      $display("FAIL frame_count: got %0d outputs want %0d", obs.size(), exp_q.size());
    end
    while (obs.size() && exp_q.size()) begin
      o = obs.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL frame: got pix=%0d cnt=%0d done=%0d cyc=%0d want pix=%0d cnt=%0d done=%0d cyc=%0d", o.pix, o.cnt, o.done, o.cyc, e.pix, e.cnt, e.done, e.cyc);
      end
    end
    total++;
    if (bus.PixelCount !== 19'(ecnt)) begin
      bad++;
      $display("FAIL frame_final_count: got %0d want %0d", bus.PixelCount, ecnt);
    end
    obs.delete();
    exp_q.delete();
  endtask
  initial begin
    bus.StartIn = 0;
    bus.DataIn = '0;
    bus.Denom = '0;
    test_reset();
    test_known();
    test_edges();
    test_back_to_back();
    test_random();
    test_midreset();
    test_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
